// File: rtl/piso_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piso_serializer : parallel-in/serial-out transmitter, MSB first on strobes
// Rev 1.0
// ----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic last_take;
  assign last_take = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST) && shift_en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (cnt_q == CNT_LAST) begin
            done_d = 1'b1;
            // Reloading on the last strobe keeps the link gap-free
            if (load_valid) begin
              shreg_d = data_in;
              cnt_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == ST_IDLE) || last_take;
    out_valid  = (state_q == ST_SHIFT);
    busy       = (state_q == ST_SHIFT);
    out        = (state_q == ST_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
    done       = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_piso_serializer : directed + random checks against a word-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load_ready, out, out_valid, busy, done;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .shift_en   (shift_en),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Word-level model: the current word and how many of its bits remain
  int           bits_left = 0;
  logic [W-1:0] cur_word = '0;
  logic         done_pend = 1'b0;
  bit           model_ok = 1'b0;

  // Receiver side: shift register fed at the LSB, plus a 16-bit stream capture
  logic [W-1:0] rx = '0;
  logic [15:0]  stream = '0;
  int           done_seen = 0;
  int           invalid_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic lv, input logic [W-1:0] din, input logic se);
    logic rdy_exp;
    logic out_exp;
    reset_n    = rn;
    load_valid = lv;
    data_in    = din;
    shift_en   = se;
    #3;
    rdy_exp = (bits_left == 0) || (bits_left == 1 && se);
    out_exp = (bits_left > 0) ? cur_word[bits_left-1] : 1'b0;
    if (model_ok) begin
      chk("out_valid",  32'(out_valid),  32'(bits_left > 0));
      chk("busy",       32'(busy),       32'(bits_left > 0));
      chk("out",        32'(out),        32'(out_exp));
      chk("done",       32'(done),       32'(done_pend));
      chk("load_ready", 32'(load_ready), 32'(rdy_exp));
    end
    if (done === 1'b1) done_seen++;
    if (out_valid !== 1'b1) invalid_cycles++;
    if (rn && out_valid === 1'b1 && se) begin
      rx     = {rx[W-2:0], out};
      stream = {stream[14:0], out};
    end
    if (!rn) begin
      bits_left = 0;
      done_pend = 1'b0;
      model_ok  = 1'b1;
    end else begin
      done_pend = 1'b0;
      if (bits_left > 0 && se) begin
        bits_left--;
        if (bits_left == 0) done_pend = 1'b1;
      end
      if (lv && rdy_exp) begin
        cur_word  = din;
        bits_left = W;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int i;
    @(posedge clk);
    #1;

    // reset
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("reset_load_ready", 32'(load_ready), 32'd1);

    // single word, strobe held high
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    rx = '0; done_seen = 0;
    for (int k = 0; k < W; k++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("a5_rx", 32'(rx), 32'h A5);
    chk("a5_done_count", 32'(done_seen), 32'd1);

    // stalled strobes
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    rx = '0; done_seen = 0; i = 0;
    while (bits_left > 0 && i < 40) begin
      step(1'b1, 1'b0, '0, (i % 3) == 0);
      i++;
    end
    if (i >= 40) chk("stall_timeout", 32'(bits_left), 32'd0);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("3c_rx", 32'(rx), 32'h3C);
    chk("3c_done_count", 32'(done_seen), 32'd1);

    // back-to-back words
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    stream = '0; done_seen = 0; invalid_cycles = 0;
    for (int k = 0; k < W - 1; k++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 8'h01, 1'b1);
    for (int k = 0; k < W; k++) step(1'b1, 1'b0, '0, 1'b1);
    chk("b2b_gap_cycles", 32'(invalid_cycles), 32'd0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("b2b_stream", 32'(stream), 32'h FF01);
    chk("b2b_done_count", 32'(done_seen), 32'd2);

    // load attempt while busy is ignored
    step(1'b1, 1'b1, 8'h9A, 1'b0);
    rx = '0;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk("busy_load_ready", 32'(load_ready), 32'd0);
    for (int k = 0; k < W - 3; k++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("9a_rx", 32'(rx), 32'h9A);

    // reset mid-word
    step(1'b1, 1'b1, 8'hC3, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, '0, 1'b1);
    done_seen = 0;
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, '0, 1'b1);
    chk("midreset_done_count", 32'(done_seen), 32'd0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 60) != 0, 1'($urandom_range(0, 1)),
           W'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
